// File: rtl/bcd_to_bin_if.sv
// Handshake and result bundle for the BCD-to-binary converter.
// The master side requests conversions; the slave side (converter) reports results.
interface bcd_to_bin_if;
    logic       start;
    logic [7:0] bcd_in;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] bin_out;
    logic       err;

    modport master (
        output start, bcd_in, carry_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in, carry_in,
        output busy, done, bin_out, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Three-digit BCD (hundreds digit 0/1) to 8-bit binary converter.
// Uses a reverse double-dabble sequence: one shift/correct step per cycle, 8 steps.
module bcd_to_bin (
    input  logic           clk,
    input  logic           rst,
    bcd_to_bin_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CONV,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] bcd_sr;
    logic [7:0]  acc;
    logic [2:0]  cnt;
    logic [7:0]  bin_q;
    logic        err_q;

    logic [19:0] shifted;
    logic [11:0] bcd_step;
    logic        nibble_bad;

    // One reverse double-dabble step: shift right, then pull every nibble >= 8 down by 3.
    always_comb begin
        shifted  = {bcd_sr, acc} >> 1;
        bcd_step = shifted[19:8];
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_step[i*4 +: 4] >= 4'd8) begin
                bcd_step[i*4 +: 4] = bcd_step[i*4 +: 4] - 4'd3;
            end
        end
        nibble_bad = (bcd_sr[7:4] > 4'd9) || (bcd_sr[3:0] > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CHECK;
            CHECK:   state_nxt = nibble_bad ? DONE : CONV;
            CONV:    if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? CHECK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        bcd_sr <= {3'b000, bus.carry_in, bus.bcd_in};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (nibble_bad) begin
                        bin_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                CONV: begin
                    bcd_sr <= bcd_step;
                    acc    <= shifted[7:0];
                    cnt    <= cnt + 3'd1;
                    // Results are published only on the final step so they stay stable mid-conversion.
                    if (cnt == 3'd7) begin
                        bin_q <= shifted[7:0];
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == CHECK) || (state == CONV);
    assign bus.done    = (state == DONE);
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized operands
// compared against an arithmetic reference model.
module tb_bcd_to_bin;

    logic clk = 1'b0;
    logic rst;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_bin = 8'h00;
    logic       exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, or error when any low nibble is not a digit.
    task automatic ref_model(input logic [7:0] bcd, input logic c,
                             output logic [7:0] val, output logic e);
        int tens;
        int units;
        tens  = int'(bcd[7:4]);
        units = int'(bcd[3:0]);
        e     = (tens > 9) || (units > 9);
        val   = e ? 8'd0 : 8'(100 * int'(c) + 10 * tens + units);
    endtask

    task automatic run_conv(input logic [7:0] bcd, input logic c,
                            input logic [7:0] late_bcd, input int pulse_at);
        logic [7:0] val;
        logic       e;
        int         lat;
        ref_model(bcd, c, val, e);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.bcd_in   = bcd;
        bus.carry_in = c;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.bcd_in   = late_bcd;
        bus.carry_in = ~c;
        lat = 0;
        while (!bus.done && lat < 20) begin
            check("busy_during", 32'(bus.busy), 32'd1);
            check("bin_hold", 32'(bus.bin_out), 32'(exp_bin));
            check("err_hold", 32'(bus.err), 32'(exp_err));
            @(posedge clk);
            #1;
            lat++;
            bus.start = (lat == pulse_at);
        end
        bus.start = 1'b0;
        check("latency", 32'(lat), e ? 32'd1 : 32'd9);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bin_out", 32'(bus.bin_out), 32'(val));
        check("err", 32'(bus.err), 32'(e));
        exp_bin = val;
        exp_err = e;
        @(posedge clk);
        #1;
        check("done_single", 32'(bus.done), 32'd0);
        check("idle_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int         gap;
        int         ndone;
        logic [7:0] rb;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.bcd_in   = 8'h00;
        bus.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio", 32'(bus.busy), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;

        run_conv(8'h99, 1'b1, 8'h00, -1);
        run_conv(8'h47, 1'b0, 8'h99, -1);
        run_conv(8'h00, 1'b0, 8'h55, -1);
        run_conv(8'h3A, 1'b0, 8'h12, -1);
        run_conv(8'h12, 1'b0, 8'h3A, -1);
        run_conv(8'h21, 1'b0, 8'h99, -1);
        run_conv(8'hA3, 1'b1, 8'h00, -1);
        run_conv(8'h64, 1'b0, 8'h11, 4);

        // Reset during the fourth CONV cycle.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 8'h73;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_bin", 32'(bus.bin_out), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        exp_bin = 8'h00;
        exp_err = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("midrst_nodone", 32'(ndone), 32'd0);
        run_conv(8'h05, 1'b0, 8'h77, -1);

        // Start held high: back-to-back conversions every 10 cycles.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.bcd_in   = 8'h50;
        bus.carry_in = 1'b0;
        gap   = 0;
        ndone = 0;
        for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
            @(posedge clk);
            #1;
            gap++;
            if (bus.done) begin
                check("held_bin", 32'(bus.bin_out), 32'h32);
                check("held_gap", 32'(gap), ndone == 0 ? 32'd10 : 32'd10);
                ndone++;
                gap = 0;
            end
        end
        check("held_count", 32'(ndone), 32'd3);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        exp_bin = 8'h32;
        exp_err = 1'b0;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rb = 8'($urandom);
            end else begin
                rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            run_conv(rb, 1'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
